// File: rtl/pipe_pkg.sv
// Shared mode selectors and occupancy-state encoding for pipe_stage_reg and
// anything that needs to reason about its internal state.
package pipe_pkg;

  localparam int MODE_BYPASS = 0;
  localparam int MODE_REG1   = 1;
  localparam int MODE_SKID   = 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // Number of valid entries held in a given occupancy state.
  function automatic logic [1:0] state_count(input state_e st);
    case (st)
      ST_BUSY: return 2'd1;
      ST_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// W-bit load-enable payload register with asynchronous reset to RST_VAL.
module pipe_data_reg #(
  parameter int           W       = 224,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= RST_VAL;
    end else if (load_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage: combinational bypass, single-entry register,
// or two-entry skid buffer whose s_ready is fully registered.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int           W       = 224,
  parameter int           MODE    = MODE_SKID,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data,
  input  logic         flush,
  output logic [1:0]   count
);

  if (MODE == MODE_BYPASS) begin : g_bypass

    logic unused_ok;
    assign unused_ok = ^{clk, rst};

    assign s_ready = m_ready;
    assign m_valid = s_valid & ~flush;
    assign m_data  = s_data;
    assign count   = 2'd0;

  end else if (MODE == MODE_REG1) begin : g_reg1

    logic         full_q;
    logic         full_d;
    logic         rdy_q;
    logic         acc;
    logic         out_xfer;
    logic [W-1:0] main_q;

    // rdy_q keeps s_ready low until the first edge after reset releases.
    assign m_valid  = full_q & ~flush;
    assign s_ready  = rdy_q & (~full_q | m_ready);
    assign acc      = s_valid & s_ready & ~flush;
    assign out_xfer = m_valid & m_ready;

    always_comb begin
      full_d = full_q;
      if (flush) begin
        full_d = 1'b0;
      end else if (acc) begin
        full_d = 1'b1;
      end else if (out_xfer) begin
        full_d = 1'b0;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        full_q <= 1'b0;
        rdy_q  <= 1'b0;
      end else begin
        full_q <= full_d;
        rdy_q  <= 1'b1;
      end
    end

    pipe_data_reg #(
      .W       (W),
      .RST_VAL (RST_VAL)
    ) u_main (
      .clk    (clk),
      .rst    (rst),
      .load_i (acc),
      .d_i    (s_data),
      .q_o    (main_q)
    );

    assign m_data = main_q;
    assign count  = {1'b0, full_q};

  end else begin : g_skid

    state_e       state_q;
    logic         s_ready_q;
    logic         acc;
    logic         out_xfer;
    logic         main_load;
    logic         skid_load;
    logic [W-1:0] main_d;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;

    assign m_valid  = (state_q != ST_EMPTY) & ~flush;
    assign acc      = s_valid & s_ready_q & ~flush;
    assign out_xfer = m_valid & m_ready;

    // The skid entry only fills when the main entry is stalled; on drain it
    // slides forward so m_data always comes from the main entry.
    always_comb begin
      main_load = 1'b0;
      skid_load = 1'b0;
      main_d    = s_data;
      case (state_q)
        ST_EMPTY: main_load = acc;
        ST_BUSY: begin
          main_load = acc & out_xfer;
          skid_load = acc & ~out_xfer;
        end
        ST_FULL: begin
          main_load = out_xfer;
          main_d    = skid_q;
        end
        default: ;
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q   <= ST_EMPTY;
        s_ready_q <= 1'b0;
      end else if (flush) begin
        state_q   <= ST_EMPTY;
        s_ready_q <= 1'b1;
      end else begin
        case (state_q)
          ST_EMPTY: begin
            if (acc) state_q <= ST_BUSY;
            s_ready_q <= 1'b1;
          end
          ST_BUSY: begin
            if (acc && !out_xfer) begin
              state_q   <= ST_FULL;
              s_ready_q <= 1'b0;
            end else begin
              if (out_xfer && !acc) state_q <= ST_EMPTY;
              s_ready_q <= 1'b1;
            end
          end
          ST_FULL: begin
            if (out_xfer) begin
              state_q   <= ST_BUSY;
              s_ready_q <= 1'b1;
            end else begin
              s_ready_q <= 1'b0;
            end
          end
          default: begin
            state_q   <= ST_EMPTY;
            s_ready_q <= 1'b1;
          end
        endcase
      end
    end

    pipe_data_reg #(
      .W       (W),
      .RST_VAL (RST_VAL)
    ) u_main (
      .clk    (clk),
      .rst    (rst),
      .load_i (main_load),
      .d_i    (main_d),
      .q_o    (main_q)
    );

    pipe_data_reg #(
      .W       (W),
      .RST_VAL (RST_VAL)
    ) u_skid (
      .clk    (clk),
      .rst    (rst),
      .load_i (skid_load),
      .d_i    (s_data),
      .q_o    (skid_q)
    );

    assign s_ready = s_ready_q;
    assign m_data  = main_q;
    assign count   = state_count(state_q);

  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID, REG1 and BYPASS instances checked against
// queue-based FIFO reference models plus directed scenario constants.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int WS = 224;
  localparam int WR = 16;
  localparam int WB = 8;
  localparam logic [WS-1:0] RST_S = {7{32'hC0FFEE01}};
  localparam logic [WR-1:0] RST_R = 16'h0BAD;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          sValidS, sReadyS, mValidS, mReadyS, flushS;
  logic [WS-1:0] sDataS, mDataS;
  logic [1:0]    countS;
  logic          sValidR, sReadyR, mValidR, mReadyR, flushR;
  logic [WR-1:0] sDataR, mDataR;
  logic [1:0]    countR;
  logic          sValidB, sReadyB, mValidB, mReadyB, flushB;
  logic [WB-1:0] sDataB, mDataB;
  logic [1:0]    countB;

  pipe_stage_reg #(.W(WS), .MODE(MODE_SKID), .RST_VAL(RST_S)) dutSkid (
    .clk(clk), .rst(rst), .s_valid(sValidS), .s_ready(sReadyS), .s_data(sDataS),
    .m_valid(mValidS), .m_ready(mReadyS), .m_data(mDataS), .flush(flushS), .count(countS));

  pipe_stage_reg #(.W(WR), .MODE(MODE_REG1), .RST_VAL(RST_R)) dutReg1 (
    .clk(clk), .rst(rst), .s_valid(sValidR), .s_ready(sReadyR), .s_data(sDataR),
    .m_valid(mValidR), .m_ready(mReadyR), .m_data(mDataR), .flush(flushR), .count(countR));

  pipe_stage_reg #(.W(WB), .MODE(MODE_BYPASS), .RST_VAL(8'h00)) dutByp (
    .clk(clk), .rst(rst), .s_valid(sValidB), .s_ready(sReadyB), .s_data(sDataB),
    .m_valid(mValidB), .m_ready(mReadyB), .m_data(mDataB), .flush(flushB), .count(countB));

  int checks = 0;
  int errors = 0;

  // Reference models: plain FIFOs of capacity 2 (SKID) and 1 (REG1).
  logic [WS-1:0] qS[$];
  logic [WR-1:0] qR[$];
  logic rdyS = 1'b0;
  logic rdyR = 1'b0;

  task automatic idleAll();
    sValidS = 0; mReadyS = 0; flushS = 0; sDataS = '0;
    sValidR = 0; mReadyR = 0; flushR = 0; sDataR = '0;
    sValidB = 0; mReadyB = 0; flushB = 0; sDataB = '0;
  endtask

  // Compare both clocked DUTs to their models, then advance one clock.
  task automatic cycle();
    logic expRdyS, expMvS, accS, outS, expRdyR, expMvR, accR, outR;
    logic [1:0] expCntS, expCntR;
    #1;
    expRdyS = rdyS;
    expMvS  = (qS.size() > 0) && !flushS;
    expCntS = 2'(qS.size());
    expRdyR = rdyR && ((qR.size() == 0) || mReadyR);
    expMvR  = (qR.size() > 0) && !flushR;
    expCntR = 2'(qR.size());
    checks++;
    if (sReadyS !== expRdyS) begin errors++; $display("[TB] FAIL skid_s_ready: got %b expected %b", sReadyS, expRdyS); end
    checks++;
    if (mValidS !== expMvS) begin errors++; $display("[TB] FAIL skid_m_valid: got %b expected %b", mValidS, expMvS); end
    checks++;
    if (countS !== expCntS) begin errors++; $display("[TB] FAIL skid_count: got %0d expected %0d", countS, expCntS); end
    if (expMvS) begin
      checks++;
      if (mDataS !== qS[0]) begin errors++; $display("[TB] FAIL skid_m_data: got %h expected %h", mDataS, qS[0]); end
    end
    checks++;
    if (sReadyR !== expRdyR) begin errors++; $display("[TB] FAIL reg1_s_ready: got %b expected %b", sReadyR, expRdyR); end
    checks++;
    if (mValidR !== expMvR) begin errors++; $display("[TB] FAIL reg1_m_valid: got %b expected %b", mValidR, expMvR); end
    checks++;
    if (countR !== expCntR) begin errors++; $display("[TB] FAIL reg1_count: got %0d expected %0d", countR, expCntR); end
    if (expMvR) begin
      checks++;
      if (mDataR !== qR[0]) begin errors++; $display("[TB] FAIL reg1_m_data: got %h expected %h", mDataR, qR[0]); end
    end
    accS = sValidS && expRdyS && !flushS;
    outS = expMvS && mReadyS;
    accR = sValidR && expRdyR && !flushR;
    outR = expMvR && mReadyR;
    @(posedge clk);
    if (rst) begin
      qS.delete(); qR.delete(); rdyS = 1'b0; rdyR = 1'b0;
    end else begin
      if (flushS) qS.delete();
      else begin
        if (outS) void'(qS.pop_front());
        if (accS) qS.push_back(sDataS);
      end
      rdyS = (qS.size() < 2);
      if (flushR) qR.delete();
      else begin
        if (outR) void'(qR.pop_front());
        if (accR) qR.push_back(sDataR);
      end
      rdyR = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic flushBoth();
    idleAll();
    flushS = 1; flushR = 1;
    cycle();
    idleAll();
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (mValidS !== 1'b0) begin errors++; $display("[TB] FAIL rst_skid_m_valid: got %b expected 0", mValidS); end
    checks++;
    if (mDataS !== RST_S) begin errors++; $display("[TB] FAIL rst_skid_m_data: got %h expected %h", mDataS, RST_S); end
    checks++;
    if (countS !== 2'd0) begin errors++; $display("[TB] FAIL rst_skid_count: got %0d expected 0", countS); end
    checks++;
    if (sReadyS !== 1'b0) begin errors++; $display("[TB] FAIL rst_skid_s_ready: got %b expected 0", sReadyS); end
    checks++;
    if (sReadyR !== 1'b0) begin errors++; $display("[TB] FAIL rst_reg1_s_ready: got %b expected 0", sReadyR); end
    checks++;
    if (mDataR !== RST_R) begin errors++; $display("[TB] FAIL rst_reg1_m_data: got %h expected %h", mDataR, RST_R); end
    @(negedge clk);
    sValidS = 1; sDataS = WS'(32'h1234); sValidR = 1; mReadyR = 1;
    cycle();
    idleAll();
    rst = 0;
    cycle();
    checks++;
    if (sReadyS !== 1'b1) begin errors++; $display("[TB] FAIL rst_release_skid_s_ready: got %b expected 1", sReadyS); end
    checks++;
    if (sReadyR !== 1'b1) begin errors++; $display("[TB] FAIL rst_release_reg1_s_ready: got %b expected 1", sReadyR); end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 8; i++) begin
      sValidS = 1; mReadyS = 1; sDataS = WS'(8'h11 + i);
      cycle();
      checks++;
      if (mValidS !== 1'b1 || mDataS !== WS'(8'h11 + i))
        begin errors++; $display("[TB] FAIL stream_data: got %b/%h expected 1/%h", mValidS, mDataS[7:0], 8'h11 + i); end
      checks++;
      if (sReadyS !== 1'b1 || countS === 2'd2)
        begin errors++; $display("[TB] FAIL stream_flow: got ready %b count %0d expected ready 1 count<2", sReadyS, countS); end
    end
    sValidS = 0;
    cycle();
    idleAll();
  endtask

  task automatic test_skid_stall();
    sValidS = 1; mReadyS = 0; sDataS = WS'(8'hA1);
    cycle();
    sDataS = WS'(8'hA2);
    cycle();
    sValidS = 0;
    checks++;
    if (countS !== 2'd2 || sReadyS !== 1'b0)
      begin errors++; $display("[TB] FAIL stall_full: got count %0d ready %b expected count 2 ready 0", countS, sReadyS); end
    mReadyS = 1;
    cycle();
    checks++;
    if (sReadyS !== 1'b1 || mDataS !== WS'(8'hA2) || countS !== 2'd1)
      begin errors++; $display("[TB] FAIL stall_drain1: got ready %b data %h count %0d expected 1/a2/1", sReadyS, mDataS[7:0], countS); end
    cycle();
    checks++;
    if (countS !== 2'd0 || mValidS !== 1'b0)
      begin errors++; $display("[TB] FAIL stall_drain2: got count %0d valid %b expected 0/0", countS, mValidS); end
    idleAll();
  endtask

  task automatic test_skid_flush();
    sValidS = 1; mReadyS = 0; sDataS = WS'(8'hB1);
    cycle();
    sDataS = WS'(8'hB2);
    cycle();
    sValidS = 0; flushS = 1; mReadyS = 1;
    #1;
    checks++;
    if (mValidS !== 1'b0) begin errors++; $display("[TB] FAIL flush_m_valid: got %b expected 0", mValidS); end
    cycle();
    flushS = 0;
    checks++;
    if (countS !== 2'd0 || sReadyS !== 1'b1)
      begin errors++; $display("[TB] FAIL flush_after: got count %0d ready %b expected 0/1", countS, sReadyS); end
    for (int i = 0; i < 2; i++) begin
      cycle();
      checks++;
      if (mValidS !== 1'b0) begin errors++; $display("[TB] FAIL flush_leak: got m_valid %b data %h expected 0", mValidS, mDataS[7:0]); end
    end
    idleAll();
  endtask

  task automatic test_reg1_concurrent();
    sValidR = 1; mReadyR = 0; sDataR = 16'h0055;
    cycle();
    sDataR = 16'h0066; mReadyR = 1;
    #1;
    checks++;
    if (sReadyR !== 1'b1 || mValidR !== 1'b1 || mDataR !== 16'h0055)
      begin errors++; $display("[TB] FAIL reg1_swap_before: got %b/%b/%h expected 1/1/0055", sReadyR, mValidR, mDataR); end
    cycle();
    checks++;
    if (mDataR !== 16'h0066 || countR !== 2'd1 || mValidR !== 1'b1)
      begin errors++; $display("[TB] FAIL reg1_swap_after: got %h count %0d valid %b expected 0066/1/1", mDataR, countR, mValidR); end
    idleAll();
    mReadyR = 1;
    cycle();
    idleAll();
  endtask

  task automatic test_bypass();
    logic expMv;
    sValidB = 1; sDataB = 8'h3C; mReadyB = 0; flushB = 0;
    #1;
    checks++;
    if (mValidB !== 1'b1 || mDataB !== 8'h3C || sReadyB !== 1'b0 || countB !== 2'd0)
      begin errors++; $display("[TB] FAIL bypass_pass: got %b/%h/%b/%0d expected 1/3c/0/0", mValidB, mDataB, sReadyB, countB); end
    flushB = 1;
    #1;
    checks++;
    if (mValidB !== 1'b0) begin errors++; $display("[TB] FAIL bypass_flush: got %b expected 0", mValidB); end
    for (int i = 0; i < 20; i++) begin
      sValidB = 1'($urandom_range(0, 1)); mReadyB = 1'($urandom_range(0, 1));
      flushB = ($urandom_range(0, 3) == 0); sDataB = 8'($urandom());
      #1;
      expMv = sValidB && !flushB;
      checks++;
      if (mValidB !== expMv || mDataB !== sDataB || sReadyB !== mReadyB || countB !== 2'd0)
        begin errors++; $display("[TB] FAIL bypass_rand: got %b/%h/%b expected %b/%h/%b", mValidB, mDataB, sReadyB, expMv, sDataB, mReadyB); end
    end
    idleAll();
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      sValidS = 1'($urandom_range(0, 1));
      mReadyS = 1'($urandom_range(0, 1));
      flushS  = ($urandom_range(0, 15) == 0);
      for (int k = 0; k < 7; k++) sDataS[k*32 +: 32] = $urandom();
      sValidR = 1'($urandom_range(0, 1));
      mReadyR = 1'($urandom_range(0, 1));
      flushR  = ($urandom_range(0, 15) == 0);
      sDataR  = 16'($urandom());
      cycle();
    end
    idleAll();
  endtask

  task automatic test_async_reset();
    flushBoth();
    sValidS = 1; mReadyS = 0; sDataS = WS'(8'hC1);
    cycle();
    sDataS = WS'(8'hC2);
    cycle();
    idleAll();
    checks++;
    if (countS !== 2'd2) begin errors++; $display("[TB] FAIL arst_pre_count: got %0d expected 2", countS); end
    #2;
    rst = 1;
    #1;
    checks++;
    if (mValidS !== 1'b0 || mDataS !== RST_S)
      begin errors++; $display("[TB] FAIL arst_out: got %b/%h expected 0/%h", mValidS, mDataS, RST_S); end
    checks++;
    if (countS !== 2'd0 || sReadyS !== 1'b0)
      begin errors++; $display("[TB] FAIL arst_state: got count %0d ready %b expected 0/0", countS, sReadyS); end
    qS.delete(); qR.delete(); rdyS = 1'b0; rdyR = 1'b0;
    @(negedge clk);
    rst = 0;
    mReadyS = 1;
    cycle();
    checks++;
    if (sReadyS !== 1'b1 || mValidS !== 1'b0)
      begin errors++; $display("[TB] FAIL arst_release: got ready %b valid %b expected 1/0", sReadyS, mValidS); end
    idleAll();
    cycle();
  endtask

  initial begin
    rst = 1;
    idleAll();
    $display("[TB] start");
    test_reset();
    test_stream();
    test_skid_stall();
    test_skid_flush();
    test_reg1_concurrent();
    test_bypass();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter W, default 224, payload width in bits (1..1024).
REQ-002 Parameter MODE, default 2, selects stage behaviour: 0 = BYPASS, 1 = REG1, 2 = SKID.
REQ-003 Parameter RST_VAL, default 0 (W bits), payload value held after reset.
REQ-004 Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  upstream offers s_data.
- s_ready  out  1  stage accepts this cycle.
- s_data  in  W  upstream payload.
- m_valid  out  1  stage offers m_data downstream.
- m_ready  in  1  downstream accepts.
- m_data  out  W  downstream payload.
- flush  in  1  synchronous kill of all held and incoming entries.
- count  out  2  number of valid entries held, 0..2.

Function
REQ-005 Input transfer SHALL occur only on the rising clk edge where s_valid and s_ready are both 1; output transfer SHALL occur only where m_valid and m_ready are both 1.
REQ-006 While m_valid=1 and m_ready=0, m_data SHALL remain unchanged.
REQ-007 BYPASS: s_ready=m_ready, m_valid=s_valid & ~flush, m_data=s_data, count=0; latency 0; no state.
REQ-008 REG1: one entry; s_ready = ~full | m_ready (combinational from m_ready); latency 1 cycle; sustains 1 transfer/cycle.
REQ-009 SKID: main entry plus skid entry; s_ready SHALL be a registered signal, equal to ~skid_full, with no combinational path from m_ready; latency 1 cycle; sustains 1 transfer/cycle.
REQ-010 SKID state machine:
- EMPTY: accept -> BUSY.
- BUSY: accept without output -> FULL; output without accept -> EMPTY; both or neither -> BUSY.
- FULL: output -> BUSY, skid entry moves to main; s_valid ignored because s_ready=0.
REQ-011 m_valid SHALL be 1 exactly in BUSY and FULL (REG1: when the entry is full), m_data SHALL always come from the main entry, and count SHALL be 0/1/2 for EMPTY/BUSY/FULL.
REQ-012 Ordering SHALL be strict FIFO; no entry is duplicated or dropped except by flush.
REQ-013 flush=1 SHALL force m_valid=0 in the same cycle, discard any input accepted that cycle, and set the state to EMPTY (count=0) at the next edge; s_ready SHALL be 1 on the following cycle.
REQ-014 flush and an output handshake in the same cycle: no output transfer SHALL be counted, because m_valid is forced to 0.
REQ-015 Payload registers SHALL load only on an accepted input; flush SHALL clear only the valid/state bits, not the payload registers.

Reset
REQ-016 rst=1 SHALL asynchronously force state EMPTY, count=0, m_valid=0 and the payload registers to RST_VAL.
REQ-017 During reset, s_ready SHALL be 0 in SKID and REG1; s_ready SHALL become 1 on the first edge after rst deasserts.
REQ-018 Reset asserted mid-transfer SHALL discard all held entries with no partial output.

Structure
REQ-019 A shared package pipe_pkg SHALL hold the MODE constants (MODE_BYPASS, MODE_REG1, MODE_SKID) and the state enum (ST_EMPTY, ST_BUSY, ST_FULL).
REQ-020 One sub-module, pipe_data_reg, SHALL implement a W-bit load-enable register with async reset to RST_VAL, instantiated once for the main entry and, in SKID mode only, once for the skid entry.
REQ-021 MODE SHALL be resolved by generate blocks; unused-mode logic SHALL NOT be synthesised.

Verification
REQ-022 SKID, m_ready=1, stream 0x11..0x18 on consecutive cycles -> m_data 0x11..0x18 each one cycle later, s_ready constantly 1, count never 2.
REQ-023 SKID, accept 0xA1 and 0xA2 while m_ready=0 -> count=2 and s_ready=0 next cycle; raise m_ready -> outputs 0xA1 then 0xA2 on consecutive cycles, s_ready back to 1 one cycle after the first output.
REQ-024 REG1, full with 0x55, m_ready=1 and s_valid=1 carrying 0x66 in the same cycle -> 0x55 leaves and 0x66 is captured in that cycle, count stays 1.
REQ-025 SKID FULL (0xB1, 0xB2) with flush=1 and m_ready=1 -> m_valid=0 that cycle, count=0 next cycle, neither 0xB1 nor 0xB2 ever appears on the output.
REQ-026 Assert rst asynchronously between edges while count=2 -> m_valid=0 and m_data=RST_VAL immediately, s_ready=1 on the first edge after deassertion.
REQ-027 BYPASS with s_valid=1, s_data=0x3C, m_ready=0 -> m_valid=1, m_data=0x3C and s_ready=0 combinationally; flush=1 -> m_valid=0.
